// File: rtl/ula_pkg.sv
// Shared definitions for the sequential ALU-control unit: ALU control codes,
// aluOp/funct encodings, FSM state type and shift-kind helper.
package ula_pkg;

    localparam logic [3:0] ALU_SLL  = 4'b0000;
    localparam logic [3:0] ALU_SRL  = 4'b0001;
    localparam logic [3:0] ALU_SRA  = 4'b0010;
    localparam logic [3:0] ALU_SLLV = 4'b0011;
    localparam logic [3:0] ALU_SRLV = 4'b0100;
    localparam logic [3:0] ALU_SRAV = 4'b0101;
    localparam logic [3:0] ALU_JR   = 4'b0110;
    localparam logic [3:0] ALU_ADD  = 4'b0111;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_AND  = 4'b1001;
    localparam logic [3:0] ALU_OR   = 4'b1010;
    localparam logic [3:0] ALU_XOR  = 4'b1011;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_SLT  = 4'b1101;
    localparam logic [3:0] ALU_SLTU = 4'b1110;
    localparam logic [3:0] ALU_ILL  = 4'b1111;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_R0  = 3'b110;
    localparam logic [2:0] OP_R1  = 3'b111;

    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_SRA  = 6'b000011;
    localparam logic [5:0] F_SLLV = 6'b000100;
    localparam logic [5:0] F_SRLV = 6'b000110;
    localparam logic [5:0] F_SRAV = 6'b000111;
    localparam logic [5:0] F_JR   = 6'b001000;
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_XOR  = 6'b100110;
    localparam logic [5:0] F_NOR  = 6'b100111;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_SLTU = 6'b101011;

    localparam logic [1:0] SH_LL = 2'b00;
    localparam logic [1:0] SH_RL = 2'b01;
    localparam logic [1:0] SH_RA = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    function automatic logic [1:0] shift_kind(input logic [3:0] code);
        logic [1:0] kind;
        case (code)
            ALU_SRL, ALU_SRLV: kind = SH_RL;
            ALU_SRA, ALU_SRAV: kind = SH_RA;
            default:           kind = SH_LL;
        endcase
        return kind;
    endfunction

endpackage

// File: rtl/ula_dec.sv
// Combinational aluOp/funct decoder producing the 4-bit ALU control code
// plus shift classification flags.
module ula_dec
    import ula_pkg::*;
(
    input  logic [2:0] aluOp,
    input  logic [5:0] funct,
    output logic [3:0] code,
    output logic       is_shift,
    output logic       is_var_shift
);

    logic [3:0] code_s;

    // Map aluOp, and funct for R-type ops, onto the ALU control code.
    always_comb begin
        code_s = ALU_ILL;
        case (aluOp)
            OP_ADD: code_s = ALU_ADD;
            OP_SUB: code_s = ALU_SUB;
            OP_AND: code_s = ALU_AND;
            OP_OR:  code_s = ALU_OR;
            OP_XOR: code_s = ALU_XOR;
            OP_SLT: code_s = ALU_SLT;
            OP_R0, OP_R1: begin
                case (funct)
                    F_SLL:   code_s = ALU_SLL;
                    F_SRL:   code_s = ALU_SRL;
                    F_SRA:   code_s = ALU_SRA;
                    F_SLLV:  code_s = ALU_SLLV;
                    F_SRLV:  code_s = ALU_SRLV;
                    F_SRAV:  code_s = ALU_SRAV;
                    F_JR:    code_s = ALU_JR;
                    F_ADD:   code_s = ALU_ADD;
                    F_SUB:   code_s = ALU_SUB;
                    F_AND:   code_s = ALU_AND;
                    F_OR:    code_s = ALU_OR;
                    F_XOR:   code_s = ALU_XOR;
                    F_NOR:   code_s = ALU_NOR;
                    F_SLT:   code_s = ALU_SLT;
                    F_SLTU:  code_s = ALU_SLTU;
                    default: code_s = ALU_ILL;
                endcase
            end
            default: code_s = ALU_ILL;
        endcase
    end

    // Shift codes occupy 0..5; the variable forms are 3..5.
    assign code         = code_s;
    assign is_shift     = (code_s <= ALU_SRAV);
    assign is_var_shift = (code_s >= ALU_SLLV) && (code_s <= ALU_SRAV);

endmodule

// File: rtl/ula_ctrl_seq.sv
// Sequential ALU-control unit: decodes aluOp/funct, executes single-cycle ops
// directly and shifts iteratively. Optional overflow port: ULA_CTRL_SEQ_OVF_EN.
module ula_ctrl_seq
    import ula_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int SHIFT_STEP = 1,
    parameter int SH_W       = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        aluOp,
    input  logic [5:0]        funct,
    input  logic [SH_W-1:0]   shamt,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              jr,
    output logic              illegal
`ifdef ULA_CTRL_SEQ_OVF_EN
    ,
    output logic              overflow
`endif
);

    localparam logic [SH_W-1:0] STEP_L = SH_W'(SHIFT_STEP);

    state_t            state_r;
    logic [1:0]        kind_r;
    logic [DATA_W-1:0] shreg_r;
    logic [SH_W-1:0]   rem_r;
    logic              out_valid_r;
    logic [DATA_W-1:0] result_r;
    logic              zero_r;
    logic              jr_r;
    logic              illegal_r;
    logic              ovf_r;

    logic [3:0]        code_s;
    logic              is_shift_s;
    logic              is_var_shift_s;
    logic [SH_W-1:0]   amount_s;
    logic              accept_s;
    logic [DATA_W-1:0] sum_s;
    logic [DATA_W-1:0] diff_s;
    logic [DATA_W-1:0] res_s;
    logic              ovf_s;
    logic [SH_W-1:0]   step_s;
    logic [SH_W-1:0]   rem_nxt_s;
    logic [DATA_W-1:0] shifted_s;

    function automatic logic [DATA_W-1:0] shift_by(input logic [DATA_W-1:0] x,
                                                   input logic [SH_W-1:0]   n,
                                                   input logic [1:0]        kind);
        logic [DATA_W-1:0] y;
        case (kind)
            SH_LL:   y = x << n;
            SH_RL:   y = x >> n;
            SH_RA:   y = $signed(x) >>> n;
            default: y = x;
        endcase
        return y;
    endfunction

    ula_dec u_dec (
        .aluOp        (aluOp),
        .funct        (funct),
        .code         (code_s),
        .is_shift     (is_shift_s),
        .is_var_shift (is_var_shift_s)
    );

    assign amount_s  = is_var_shift_s ? a[SH_W-1:0] : shamt;
    assign in_ready  = (state_r == ST_IDLE) | ((state_r == ST_DONE) & out_ready);
    assign accept_s  = in_valid & in_ready;
    assign sum_s     = a + b;
    assign diff_s    = a - b;
    assign step_s    = (rem_r >= STEP_L) ? STEP_L : rem_r;
    assign rem_nxt_s = rem_r - step_s;
    assign shifted_s = shift_by(shreg_r, step_s, kind_r);

    // Single-cycle datapath; shift codes here only cover a zero amount.
    always_comb begin
        res_s = {DATA_W{1'b0}};
        ovf_s = 1'b0;
        case (code_s)
            ALU_ADD: begin
                res_s = sum_s;
                ovf_s = (a[DATA_W-1] == b[DATA_W-1]) && (sum_s[DATA_W-1] != a[DATA_W-1]);
            end
            ALU_SUB: begin
                res_s = diff_s;
                ovf_s = (a[DATA_W-1] != b[DATA_W-1]) && (diff_s[DATA_W-1] != a[DATA_W-1]);
            end
            ALU_AND:  res_s = a & b;
            ALU_OR:   res_s = a | b;
            ALU_XOR:  res_s = a ^ b;
            ALU_NOR:  res_s = ~(a | b);
            ALU_SLT:  res_s = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: res_s = {{(DATA_W-1){1'b0}}, (a < b)};
            ALU_JR:   res_s = a;
            ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLLV, ALU_SRLV, ALU_SRAV: res_s = b;
            default:  res_s = {DATA_W{1'b0}};
        endcase
    end

    // Control FSM with registered result and flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            kind_r      <= SH_LL;
            shreg_r     <= {DATA_W{1'b0}};
            rem_r       <= {SH_W{1'b0}};
            out_valid_r <= 1'b0;
            result_r    <= {DATA_W{1'b0}};
            zero_r      <= 1'b0;
            jr_r        <= 1'b0;
            illegal_r   <= 1'b0;
            ovf_r       <= 1'b0;
        end else if (accept_s) begin
            // Accept path covers both IDLE and a DONE that is being drained.
            kind_r  <= shift_kind(code_s);
            shreg_r <= b;
            rem_r   <= amount_s;
            if (is_shift_s && (amount_s != {SH_W{1'b0}})) begin
                state_r     <= ST_SHIFT;
                out_valid_r <= 1'b0;
                jr_r        <= 1'b0;
                illegal_r   <= 1'b0;
                ovf_r       <= 1'b0;
            end else begin
                state_r     <= ST_DONE;
                out_valid_r <= 1'b1;
                result_r    <= res_s;
                zero_r      <= (res_s == {DATA_W{1'b0}});
                jr_r        <= (code_s == ALU_JR);
                illegal_r   <= (code_s == ALU_ILL);
                ovf_r       <= ovf_s;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r <= ST_IDLE;
                end
                ST_SHIFT: begin
                    shreg_r <= shifted_s;
                    rem_r   <= rem_nxt_s;
                    if (rem_nxt_s == {SH_W{1'b0}}) begin
                        state_r     <= ST_DONE;
                        out_valid_r <= 1'b1;
                        result_r    <= shifted_s;
                        zero_r      <= (shifted_s == {DATA_W{1'b0}});
                    end else begin
                        state_r <= ST_SHIFT;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_r     <= ST_IDLE;
                        out_valid_r <= 1'b0;
                        jr_r        <= 1'b0;
                        illegal_r   <= 1'b0;
                        ovf_r       <= 1'b0;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    out_valid_r <= 1'b0;
                    jr_r        <= 1'b0;
                    illegal_r   <= 1'b0;
                    ovf_r       <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign zero      = zero_r;
    assign jr        = jr_r;
    assign illegal   = illegal_r;
`ifdef ULA_CTRL_SEQ_OVF_EN
    assign overflow  = ovf_r;
`else
    logic unused_ovf_s;
    assign unused_ovf_s = ovf_r ^ ovf_s;
`endif

endmodule

// File: tb/tb_ula_ctrl_seq.sv
// Self-checking bench for ula_ctrl_seq: directed steps plus random operations
// checked against a behavioural model of the decode/execute rules.
module tb_ula_ctrl_seq;

    localparam int DATA_W     = 32;
    localparam int SHIFT_STEP = 1;
    localparam int SH_W       = $clog2(DATA_W);

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        aluOp;
    logic [5:0]        funct;
    logic [SH_W-1:0]   shamt;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] result;
    logic              zero;
    logic              jr;
    logic              illegal;
`ifdef ULA_CTRL_SEQ_OVF_EN
    logic              overflow;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    ula_ctrl_seq #(.DATA_W(DATA_W), .SHIFT_STEP(SHIFT_STEP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .aluOp     (aluOp),
        .funct     (funct),
        .shamt     (shamt),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .jr        (jr),
        .illegal   (illegal)
`ifdef ULA_CTRL_SEQ_OVF_EN
        ,
        .overflow  (overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: instruction semantics computed directly from the op tables.
    task automatic model(input logic [2:0] op, input logic [5:0] f, input logic [SH_W-1:0] sh,
                         input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y,
                         output logic [DATA_W-1:0] r, output logic j, output logic ill,
                         output int lat);
        int amt;
        bit is_sh;
        r = 0; j = 0; ill = 0; amt = 0; is_sh = 0;
        if (op <= 3'd5) begin
            case (op)
                3'd0: r = x + y;
                3'd1: r = x - y;
                3'd2: r = x & y;
                3'd3: r = x | y;
                3'd4: r = x ^ y;
                default: r = ($signed(x) < $signed(y)) ? 1 : 0;
            endcase
        end else begin
            case (f)
                6'h00: begin is_sh = 1; amt = int'(sh);      r = y << amt; end
                6'h02: begin is_sh = 1; amt = int'(sh);      r = y >> amt; end
                6'h03: begin is_sh = 1; amt = int'(sh);      r = $signed(y) >>> amt; end
                6'h04: begin is_sh = 1; amt = x % DATA_W;    r = y << amt; end
                6'h06: begin is_sh = 1; amt = x % DATA_W;    r = y >> amt; end
                6'h07: begin is_sh = 1; amt = x % DATA_W;    r = $signed(y) >>> amt; end
                6'h08: begin r = x; j = 1; end
                6'h20: r = x + y;
                6'h22: r = x - y;
                6'h24: r = x & y;
                6'h25: r = x | y;
                6'h26: r = x ^ y;
                6'h27: r = ~(x | y);
                6'h2a: r = ($signed(x) < $signed(y)) ? 1 : 0;
                6'h2b: r = (x < y) ? 1 : 0;
                default: begin r = 0; ill = 1; end
            endcase
        end
        lat = (is_sh && amt != 0) ? 1 + (amt + SHIFT_STEP - 1) / SHIFT_STEP : 1;
    endtask

    task automatic do_op(input logic [2:0] op, input logic [5:0] f, input logic [SH_W-1:0] sh,
                         input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y, input int hold,
                         output logic [DATA_W-1:0] got, output int lat_got);
        logic [DATA_W-1:0] er;
        logic ej, ei;
        int el;
        int cyc;
        model(op, f, sh, x, y, er, ej, ei, el);
        @(negedge clk);
        aluOp = op; funct = f; shamt = sh; a = x; b = y;
        in_valid = 1'b1;
        out_ready = (hold > 0) ? 1'b0 : 1'b1;
        #1 check("in_ready_idle", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        aluOp = 3'($urandom); funct = 6'($urandom); shamt = SH_W'($urandom);
        a = $urandom; b = $urandom;
        cyc = 1;
        while (!out_valid && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        lat_got = cyc;
        got = result;
        check("out_valid", out_valid, 1);
        check("latency", cyc, el);
        check("result", result, er);
        check("zero", zero, (er == 0));
        check("jr", jr, ej);
        check("illegal", illegal, ei);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            #1;
            check("hold_result", result, er);
            check("hold_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("drain_valid", out_valid, 0);
        check("drain_jr", jr, 0);
        check("drain_illegal", illegal, 0);
    endtask

    initial begin
        logic [DATA_W-1:0] got;
        int lat;
        logic [5:0] legal_f [15];
        int to;
        legal_f = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h20,
                    6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        aluOp = 3'd0; funct = 6'd0; shamt = '0; a = '0; b = '0;
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_zero", zero, 0);
        check("rst_jr", jr, 0);
        check("rst_illegal", illegal, 0);
        check("rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(3'b000, 6'h00, 5'd0, 32'd5, 32'd7, 0, got, lat);
        check("add_res", got, 32'd12);
        check("add_lat", lat, 1);
        do_op(3'b110, 6'h03, 5'd4, 32'd0, 32'h8000_0000, 0, got, lat);
        check("sra_res", got, 32'hF800_0000);
        check("sra_lat", lat, 5);
        do_op(3'b110, 6'h04, 5'd0, 32'd33, 32'd1, 0, got, lat);
        check("sllv_res", got, 32'd2);
        check("sllv_lat", lat, 2);
        do_op(3'b110, 6'h04, 5'd0, 32'd32, 32'd9, 0, got, lat);
        check("sllv0_res", got, 32'd9);
        check("sllv0_lat", lat, 1);
        do_op(3'b110, 6'h2a, 5'd0, 32'hFFFF_FFFF, 32'd1, 0, got, lat);
        check("slt_res", got, 32'd1);
        do_op(3'b110, 6'h2b, 5'd0, 32'hFFFF_FFFF, 32'd1, 0, got, lat);
        check("sltu_res", got, 32'd0);
        check("sltu_zero", zero, 1);
        do_op(3'b110, 6'h3f, 5'd0, 32'd3, 32'd4, 0, got, lat);
        check("ill_res", got, 32'd0);
        do_op(3'b111, 6'h08, 5'd0, 32'h1234_5678, 32'd4, 1, got, lat);
        check("jr_res", got, 32'h1234_5678);
        do_op(3'b110, 6'h00, 5'd31, 32'd0, 32'h0000_0003, 0, got, lat);
        check("sll31_res", got, 32'h8000_0000);

`ifdef ULA_CTRL_SEQ_OVF_EN
        @(negedge clk);
        aluOp = 3'b000; a = 32'h7FFF_FFFF; b = 32'd1; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        check("ovf_add", overflow, 1);
        check("ovf_add_res", result, 32'h8000_0000);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 check("ovf_clear", overflow, 0);
`endif

        // Backpressure then same-cycle accept of the next request.
        @(negedge clk);
        aluOp = 3'b000; a = 32'd10; b = 32'd20; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        check("bp_valid", out_valid, 1);
        check("bp_res", result, 32'd30);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check("bp_stable", result, 32'd30);
            check("bp_in_ready", in_ready, 0);
        end
        @(negedge clk);
        aluOp = 3'b001; a = 32'd100; b = 32'd1; in_valid = 1'b1; out_ready = 1'b1;
        #1 check("bp_accept_ready", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        check("bp_next_valid", out_valid, 1);
        check("bp_next_res", result, 32'd99);
        @(posedge clk);
        #1 check("bp_next_drain", out_valid, 0);

        // Reset while shifting aborts the operation.
        @(negedge clk);
        aluOp = 3'b110; funct = 6'h00; shamt = 5'd20; b = 32'd1; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_result", result, 0);
        @(negedge clk);
        rst_n = 1'b1;
        to = 0;
        while (!out_valid && to < 25) begin
            @(posedge clk);
            #1 to++;
        end
        check("abort_no_result", out_valid, 0);

        for (int i = 0; i < 80; i++) begin
            logic [2:0] op;
            logic [5:0] f;
            logic [DATA_W-1:0] x, y;
            op = 3'($urandom_range(0, 7));
            f = ($urandom_range(0, 9) < 8) ? legal_f[$urandom_range(0, 14)] : 6'($urandom);
            x = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : $urandom;
            y = ($urandom_range(0, 5) == 0) ? x : $urandom;
            do_op(op, f, SH_W'($urandom), x, y, $urandom_range(0, 2), got, lat);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
